// File: rtl/sw_debounce_irq.sv
// Switch conditioner: 2-FF synchroniser, per-bit debounce, edge pulses and a W1C pending interrupt.
// Define SW_DEBOUNCE_BOTHEDGE_EN to let falling as well as rising debounced edges set pending.
module sw_debounce_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] pend_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             differ;

      assign differ     = sync2[gi] ^ sw_stable[gi];
      assign accept[gi] = differ && (cnt == CNT_LAST);

      // Any return to the stable level restarts qualification from zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (!differ || accept[gi]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

`ifdef SW_DEBOUNCE_BOTHEDGE_EN
  assign pend_set = accept & irq_mask;
`else
  assign pend_set = accept & sync2 & irq_mask;
`endif

  // Set has priority over the clear strobe so a coincident edge is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_stable   <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      irq_pending <= '0;
    end else begin
      sw_stable   <= sw_stable ^ accept;
      sw_rise     <= accept & sync2;
      sw_fall     <= accept & ~sync2;
      irq_pending <= (irq_pending & ~irq_clr) | pend_set;
    end
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_sw_debounce_irq.sv
// Bench for sw_debounce_irq: directed scenarios plus randomized traffic against an edge-level model.
module tb_sw_debounce_irq;

  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] irq_mask = '0;
  logic [W-1:0] irq_clr = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall, irq_pending;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_d1, m_d2, m_stable, m_rise, m_fall, m_pend;
  int           m_run [W];

`ifdef SW_DEBOUNCE_BOTHEDGE_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  sw_debounce_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .irq_mask(irq_mask), .irq_clr(irq_clr),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_zero();
    m_d1 = '0; m_d2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // One clock edge; the model sees the pin value two edges late and accepts
  // a level once it has differed from the stable value for DC edges in a row.
  task automatic tick();
    logic [W-1:0] seen, acc, set;
    @(posedge clk);
    if (rst) begin
      model_zero();
    end else begin
      seen = m_d2; m_d2 = m_d1; m_d1 = sw_raw;
      acc = '0;
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin acc[i] = 1'b1; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      set      = acc & irq_mask & (BOTH ? {W{1'b1}} : seen);
      m_pend   = (m_pend & ~irq_clr) | set;
      m_rise   = acc & seen;
      m_fall   = acc & ~seen;
      m_stable = m_stable ^ acc;
    end
    #1;
  endtask

  task automatic apply_reset();
    sw_raw = '0; irq_clr = '0;
    rst = 1'b1; #3; rst = 1'b0;
    model_zero();
  endtask

  task automatic test_reset();
    sw_raw = 4'hF; irq_mask = 4'hF; irq_clr = '0;
    #1;
    n_cmp++; if ({sw_stable, sw_rise, sw_fall, irq_pending, irq} !== 17'h0) begin n_err++; $display("FAIL reset_init got %h exp 0", {sw_stable, sw_rise, sw_fall, irq_pending, irq}); end
    #1 rst = 1'b0; model_zero();
    repeat (6) tick();
    n_cmp++; if (sw_stable !== 4'hF) begin n_err++; $display("FAIL reset_pre_stable got %h exp f", sw_stable); end
    sw_raw = 4'h0;
    repeat (3) tick();
    #2 rst = 1'b1; sw_raw = 4'hF; #1;
    n_cmp++; if ({sw_stable, sw_rise, sw_fall, irq_pending, irq} !== 17'h0) begin n_err++; $display("FAIL reset_async got %h exp 0", {sw_stable, sw_rise, sw_fall, irq_pending, irq}); end
    #1 rst = 1'b0; model_zero();
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 5) begin
        n_cmp++; if ({sw_stable, sw_rise, sw_fall} !== 12'h0) begin n_err++; $display("FAIL reset_e5 got %h exp 0", {sw_stable, sw_rise, sw_fall}); end
      end
      if (n == 6) begin
        n_cmp++; if (sw_stable !== 4'hF) begin n_err++; $display("FAIL reset_e6_stable got %h exp f", sw_stable); end
        n_cmp++; if (sw_rise !== 4'hF) begin n_err++; $display("FAIL reset_e6_rise got %h exp f", sw_rise); end
        n_cmp++; if (irq_pending !== irq_mask) begin n_err++; $display("FAIL reset_e6_pend got %h exp %h", irq_pending, irq_mask); end
      end
      if (n == 7) begin
        n_cmp++; if (sw_rise !== 4'h0) begin n_err++; $display("FAIL reset_e7_rise got %h exp 0", sw_rise); end
      end
    end
    $display("test_reset done: stable=%h pending=%h", sw_stable, irq_pending);
  endtask

  task automatic test_clean_press();
    apply_reset();
    irq_mask = 4'hF; sw_raw = 4'h1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n < 6) begin
        n_cmp++; if ({sw_stable, sw_rise, irq} !== 9'h0) begin n_err++; $display("FAIL press_early_e%0d got %h exp 0", n, {sw_stable, sw_rise, irq}); end
      end else if (n == 6) begin
        n_cmp++; if ({sw_stable, sw_rise, irq_pending, irq} !== {4'h1, 4'h1, 4'h1, 1'b1}) begin n_err++; $display("FAIL press_e6 got %h exp %h", {sw_stable, sw_rise, irq_pending, irq}, {4'h1, 4'h1, 4'h1, 1'b1}); end
      end else begin
        n_cmp++; if ({sw_stable, sw_rise} !== {4'h1, 4'h0}) begin n_err++; $display("FAIL press_e7 got %h exp 10", {sw_stable, sw_rise}); end
      end
    end
    $display("test_clean_press done: stable=%h irq=%b", sw_stable, irq);
  endtask

  task automatic test_bounce();
    apply_reset();
    irq_mask = 4'hF;
    for (int k = 0; k < 5; k++) begin
      sw_raw = 4'h4; repeat (3) tick();
      sw_raw = 4'h0; repeat (3) tick();
      n_cmp++; if ({sw_stable, sw_rise, sw_fall, irq} !== 13'h0) begin n_err++; $display("FAIL bounce_%0d got %h exp 0", k, {sw_stable, sw_rise, sw_fall, irq}); end
    end
    sw_raw = 4'h4;
    repeat (5) tick();
    n_cmp++; if (sw_stable !== 4'h0) begin n_err++; $display("FAIL bounce_hold_e5 got %h exp 0", sw_stable); end
    tick();
    n_cmp++; if ({sw_stable, sw_rise} !== {4'h4, 4'h4}) begin n_err++; $display("FAIL bounce_hold_e6 got %h exp 44", {sw_stable, sw_rise}); end
    $display("test_bounce done: stable=%h", sw_stable);
  endtask

  task automatic test_clear();
    apply_reset();
    irq_mask = 4'hF; sw_raw = 4'h1;
    repeat (6) tick();
    irq_clr = 4'hE; tick(); irq_clr = '0;
    n_cmp++; if (irq_pending !== 4'h1) begin n_err++; $display("FAIL clr_zero_bits got %h exp 1", irq_pending); end
    irq_clr = 4'h1; tick(); irq_clr = '0;
    n_cmp++; if ({irq_pending, irq} !== 5'h0) begin n_err++; $display("FAIL clr_w1c got %h exp 0", {irq_pending, irq}); end
    sw_raw = 4'h0; repeat (6) tick();
    irq_clr = 4'h1; tick(); irq_clr = '0;
    sw_raw = 4'h1; repeat (5) tick();
    irq_clr = 4'h1; tick(); irq_clr = '0;
    n_cmp++; if ({sw_rise, irq_pending, irq} !== {4'h1, 4'h1, 1'b1}) begin n_err++; $display("FAIL clr_vs_set got %h exp 23", {sw_rise, irq_pending, irq}); end
    $display("test_clear done: pending=%h", irq_pending);
  endtask

  task automatic test_mask();
    apply_reset();
    irq_mask = 4'b1101; sw_raw = 4'h2;
    repeat (6) tick();
    n_cmp++; if ({sw_stable, sw_rise, irq_pending, irq} !== {4'h2, 4'h2, 4'h0, 1'b0}) begin n_err++; $display("FAIL mask_blocked got %h exp 440", {sw_stable, sw_rise, irq_pending, irq}); end
    irq_mask = 4'hF; tick();
    n_cmp++; if ({irq_pending, irq} !== 5'h0) begin n_err++; $display("FAIL mask_no_retro got %h exp 0", {irq_pending, irq}); end
    sw_raw = 4'h3; repeat (6) tick();
    irq_mask = 4'h0; tick();
    n_cmp++; if (irq_pending !== 4'h1) begin n_err++; $display("FAIL mask_keeps_pend got %h exp 1", irq_pending); end
    $display("test_mask done: pending=%h", irq_pending);
  endtask

  task automatic test_fall_edge();
    apply_reset();
    irq_mask = 4'hF; sw_raw = 4'h8;
    repeat (6) tick();
    irq_clr = 4'hF; tick(); irq_clr = '0;
    sw_raw = 4'h0;
    repeat (5) tick();
    n_cmp++; if (sw_fall !== 4'h0) begin n_err++; $display("FAIL fall_early got %h exp 0", sw_fall); end
    tick();
    n_cmp++; if ({sw_stable, sw_fall, sw_rise} !== {4'h0, 4'h8, 4'h0}) begin n_err++; $display("FAIL fall_e6 got %h exp 080", {sw_stable, sw_fall, sw_rise}); end
    n_cmp++; if (irq_pending !== (BOTH ? 4'h8 : 4'h0)) begin n_err++; $display("FAIL fall_pend got %h exp %h", irq_pending, (BOTH ? 4'h8 : 4'h0)); end
    $display("test_fall_edge done: pending=%h", irq_pending);
  endtask

  task automatic test_random();
    int qual = 0;
    apply_reset();
    irq_mask = 4'($urandom);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(7) == 0) sw_raw[i] = ~sw_raw[i];
      if ($urandom_range(31) == 0) irq_mask = 4'($urandom);
      irq_clr = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
      tick();
      if ($urandom_range(499) == 0) begin
        #2 rst = 1'b1; #1;
        n_cmp++; if ({sw_stable, sw_rise, sw_fall, irq_pending, irq} !== 17'h0) begin n_err++; $display("FAIL rand_async_rst got %h exp 0", {sw_stable, sw_rise, sw_fall, irq_pending, irq}); end
        #1 rst = 1'b0; model_zero();
      end else begin
        if ((m_rise | m_fall) != 0) qual++;
        n_cmp++; if ({sw_stable, sw_rise, sw_fall} !== {m_stable, m_rise, m_fall}) begin n_err++; $display("FAIL rand_edges c=%0d got %h exp %h", c, {sw_stable, sw_rise, sw_fall}, {m_stable, m_rise, m_fall}); end
        n_cmp++; if ({irq_pending, irq} !== {m_pend, |m_pend}) begin n_err++; $display("FAIL rand_pend c=%0d got %h exp %h", c, {irq_pending, irq}, {m_pend, |m_pend}); end
      end
    end
    irq_clr = '0;
    $display("test_random done: %0d cycles with qualifying edges", qual);
  endtask

  initial begin
    model_zero();
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear();
    test_mask();
    test_fall_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_debounce_irq.md
Name: sw_debounce_irq

Overview:
- Input-conditioning stage placed directly upstream of the GPIO peripheral's switch bus.
- Synchronises raw board switches into `clk`, then debounces each bit independently.
- Drives the clean `sw_stable` bus into the GPIO switch input.
- Detects debounced edges and latches them into per-bit pending flags that form one level interrupt, cleared by write-one-to-clear from the SoC side.

Parameters:
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 50000: consecutive cycles a changed input must hold before it is accepted. Legal range 2 .. 2^CNT_W-1.
- CNT_W, 16: width of each per-bit debounce counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- sw_raw  input  WIDTH  asynchronous switch pins.
- irq_mask  input  WIDTH  1 = edge on that bit may set pending.
- irq_clr  input  WIDTH  write-one-to-clear strobe for pending bits; single-cycle.
- sw_stable  output  WIDTH  debounced switch value; feeds the GPIO switch bus.
- sw_rise  output  WIDTH  one-cycle pulse, debounced 0->1 per bit.
- sw_fall  output  WIDTH  one-cycle pulse, debounced 1->0 per bit.
- irq_pending  output  WIDTH  latched edge flags.
- irq  output  1  OR of irq_pending; level interrupt.

Behaviour:
- Reset (async assert, sync release by the system), all to 0:
  - sync1, sync2, sw_stable, all counters, sw_rise, sw_fall, irq_pending, irq.
  - Reset mid-count discards the partial count with no pulse.
  - After reset, a switch held high re-qualifies as a normal rising edge.
- Synchroniser: 2-FF per bit (sync1 <- sw_raw, sync2 <- sync1). No logic between the flops.
- Per-bit debounce, evaluated every edge:
  - sync2 == sw_stable: cnt <= 0.
  - sync2 != sw_stable and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != sw_stable and cnt == DEBOUNCE_CYCLES-1: sw_stable <= sync2, cnt <= 0, and the matching sw_rise/sw_fall is registered 1 for exactly one cycle.
  - Counter never wraps; any return to the stable value before acceptance restarts qualification from 0.
- Latency: with sw_raw changed before edge 1 and held, sw_stable and the edge pulse update at edge DEBOUNCE_CYCLES+2.
- Bits are independent; several bits may qualify in the same cycle, each pulsing its own bit.
- Pending, per bit, registered:
  - set = qualifying edge & irq_mask (edge type per Optional Feature).
  - set and irq_clr on the same edge: set wins, bit stays 1.
  - irq_clr on a 0 bit: no effect.
  - Masking does not clear an already-pending bit.
  - Pending updates on the same edge as sw_stable.
- irq = |irq_pending, combinational from registers, so no extra latency.
- No FSM beyond the per-bit counter; qualify/idle is implied by sync2 != sw_stable.

Optional Feature:
- Macro: SW_DEBOUNCE_BOTHEDGE_EN.
- Defined: pending set by rising OR falling debounced edges.
- Undefined: pending set only by rising edges.
- sw_rise/sw_fall pulses exist in both builds.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset: assert rst mid-cycle with sw_raw=4'hF and a count in progress -> all outputs 0 immediately. After release with sw_raw held, sw_stable=4'hF at edge 6, sw_rise=4'hF for one cycle, irq_pending=irq_mask.
- Clean press: irq_mask=4'hF, sw_raw[0] 0->1 before edge 1 -> sw_stable=4'h1 at edge 6, sw_rise=4'h1 one cycle only, irq_pending=4'h1, irq=1.
- Bounce: sw_raw[2] high for 3 cycles then low, repeated 5 times -> sw_stable[2] stays 0, no pulses, irq=0. Then hold high -> accepted 6 edges after the final rise.
- Clear: irq_pending=4'h1, irq_clr=4'h1 for one cycle -> irq_pending=0, irq=0 next edge. Repeat with irq_clr coinciding with a new bit-0 qualifying edge -> irq_pending[0] stays 1.
- Mask: irq_mask=4'b1101, press bit 1 -> sw_stable[1]=1 and sw_rise[1] pulse, irq_pending=0, irq=0. Then unmask -> still 0 (no retroactive set).
- Fall edge: bit 3 stable 1, release -> sw_fall[3] pulses at edge 6. With SW_DEBOUNCE_BOTHEDGE_EN: irq_pending=4'h8. Without it: irq_pending=0.
